snd_mailbox: RTL and testbench
==============================

Name: snd_mailbox

Overview:
- Parametrised command mailbox from the main CPU to the sound CPU. It replaces the single-byte sound latch and its one-cycle interrupt pulse.
- Provides CHANNELS independent FIFOs of DEPTH entries of WIDTH bits each.
- Status flags: per-channel empty, full and sticky overflow.
- Selectable interrupt modes toward the sound CPU.
- Sits between the main CPU decode (sound-latch write strobe) and the sound CPU bus / AY port-A input.

Parameters:
- WIDTH, 8: data width of each entry.
- DEPTH, 4: entries per channel; power of two, at least 1.
- CHANNELS, 2: number of independent FIFOs; at least 1.
- OVERWRITE, 0: 1 = a write to a full channel replaces the newest entry; 0 = the write is dropped.
- IRQ_MODE, 0: 0 = pulse per accepted write; 1 = level while any channel is non-empty; 2 = set on write, cleared by ack.

Ports:
- clk_sys  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mcpu_wr  in  1  main-CPU write strobe, one push per cycle high.
- mcpu_ch  in  CW  target channel for the write; CW = max(1, clog2(CHANNELS)).
- mcpu_din  in  WIDTH  write data.
- mcpu_clr_ovf  in  1  clears the overflow flag of mcpu_ch.
- scpu_rd  in  1  sound-CPU read strobe, one pop per cycle high.
- scpu_ch  in  CW  channel to read.
- scpu_dout  out  WIDTH  head data of scpu_ch.
- scpu_irq_ack  in  1  acknowledge input, used in IRQ_MODE 2 only.
- scpu_irq  out  1  interrupt to the sound CPU.
- empty  out  CHANNELS  per-channel empty flags.
- full  out  CHANNELS  per-channel full flags.
- ovf  out  CHANNELS  per-channel sticky overflow flags.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All pointers and counts are 0.
  - empty is all ones; full and ovf are all zeros.
  - scpu_irq = 0; last-read register = 0.
  - Storage contents are don't-care.
  - Release is synchronous to clk_sys; the first push is accepted on the first edge after deassertion.
- Each channel keeps a write pointer, a read pointer (both wrapping modulo DEPTH) and a count from 0 to DEPTH. empty = (count==0); full = (count==DEPTH).
- Push (mcpu_wr high):
  - Not full: store at the write pointer, advance it, increment count. The entry is visible at scpu_dout on the next cycle.
  - Full, OVERWRITE=0: write dropped, ovf[ch] set.
  - Full, OVERWRITE=1: entry at (write pointer - 1) replaced, count unchanged, ovf[ch] set.
  - DEPTH=1 with OVERWRITE=1 reproduces the legacy latch.
- Pop (scpu_rd high):
  - Not empty: the read pointer advances, count decrements, and the head value is captured into that channel's last-read register.
  - Empty: no state change.
- scpu_dout is combinational (first-word fall-through). It shows the head entry of scpu_ch when that channel is non-empty, and the channel's last-read register otherwise. Read latency is 0 cycles.
- Simultaneous push and pop on the same channel:
  - Non-empty: both occur, count unchanged. Full: no overflow.
  - Empty: the push occurs, the pop is ignored, count becomes 1.
- Simultaneous operations on different channels are independent.
- Channel index of CHANNELS or above: push and pop are ignored, scpu_dout = 0, flags unaffected.
- ovf[ch] is cleared by mcpu_clr_ovf. If an overflow occurs in the same cycle, set wins.
- Interrupt modes:
  - IRQ_MODE 0: scpu_irq is high for exactly the one cycle following each accepted or overwriting push. Dropped pushes give no pulse.
  - IRQ_MODE 1: scpu_irq is registered, equal to OR(~empty) one cycle late.
  - IRQ_MODE 2: scpu_irq is set on any push and cleared on scpu_irq_ack. If both occur in the same cycle, set wins.
- Counts never exceed DEPTH and never underflow. Pointers wrap cleanly at DEPTH-1 to 0.

Test Plan:
- Defaults: push 0x11, 0x22, 0x33 to ch0 -> scpu_dout shows 0x11 one cycle later; three pops return 0x11, 0x22, 0x33; empty[0]=1; a further read returns 0x33.
- Fill ch1 with 4 entries, then push 0x99 (OVERWRITE=0) -> full[1]=1, ovf[1]=1, the 4 pops return the original data. mcpu_clr_ovf on ch1 -> ovf[1]=0.
- OVERWRITE=1, DEPTH=1: pushes 0x05 then 0x07 without a pop -> scpu_dout=0x07, ovf[0]=1, one scpu_irq pulse per push.
- Full ch0 with simultaneous push 0xAA and pop -> count stays 4, ovf stays 0, 0xAA is popped last after 4 pops; pointer wrap is exercised over 3 full fill/drain cycles.
- IRQ_MODE 2: push -> scpu_irq=1; ack and push in the same cycle -> stays 1; a lone ack -> 0. IRQ_MODE 1: irq drops one cycle after the last pop empties all channels.
- Assert rst_n low mid-fill with 3 entries held -> immediately empty all ones, scpu_irq=0, scpu_dout=0; after release the first push is read back correctly.

Source files
------------

// File: rtl/snd_mailbox_if.sv
// Bus bundle between the main-CPU write side, the sound-CPU read side and
// the snd_mailbox FIFOs. The mailbox uses the slave view; the CPUs (or a
// bench standing in for them) use the master view.
interface snd_mailbox_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // main CPU write side
    logic                mcpu_wr;
    logic [CW-1:0]       mcpu_ch;
    logic [WIDTH-1:0]    mcpu_din;
    logic                mcpu_clr_ovf;
    // sound CPU read side
    logic                scpu_rd;
    logic [CW-1:0]       scpu_ch;
    logic [WIDTH-1:0]    scpu_dout;
    logic                scpu_irq_ack;
    logic                scpu_irq;
    // status flags
    logic [CHANNELS-1:0] empty;
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] ovf;

    modport master (
        output mcpu_wr, mcpu_ch, mcpu_din, mcpu_clr_ovf,
        output scpu_rd, scpu_ch, scpu_irq_ack,
        input  scpu_dout, scpu_irq, empty, full, ovf
    );

    modport slave (
        input  mcpu_wr, mcpu_ch, mcpu_din, mcpu_clr_ovf,
        input  scpu_rd, scpu_ch, scpu_irq_ack,
        output scpu_dout, scpu_irq, empty, full, ovf
    );
endinterface

// File: rtl/snd_mailbox.sv
// Command mailbox from the main CPU to the sound CPU: CHANNELS independent
// first-word-fall-through FIFOs of DEPTH x WIDTH, per-channel empty/full/
// sticky-overflow flags and a selectable interrupt toward the sound CPU.
// DEPTH=1 with OVERWRITE=1 behaves like the old single-byte sound latch.
module snd_mailbox #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int CHANNELS  = 2,
    parameter int OVERWRITE = 0,
    parameter int IRQ_MODE  = 0
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    snd_mailbox_if.slave   bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);
    // Storage is sized to the full pointer range so a 1-bit pointer on a
    // DEPTH=1 channel never indexes past the array; the spare slot is unused.
    localparam int MEM_D = 1 << PW;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [NW-1:0] CNT_FULL = NW'(DEPTH);

    logic [WIDTH-1:0]    mem_q    [CHANNELS][MEM_D];
    logic [PW-1:0]       wr_ptr_q [CHANNELS];
    logic [PW-1:0]       wr_ptr_d [CHANNELS];
    logic [PW-1:0]       rd_ptr_q [CHANNELS];
    logic [PW-1:0]       rd_ptr_d [CHANNELS];
    logic [NW-1:0]       cnt_q    [CHANNELS];
    logic [NW-1:0]       cnt_d    [CHANNELS];
    logic [WIDTH-1:0]    last_q   [CHANNELS];
    logic [WIDTH-1:0]    last_d   [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic                irq_q, irq_d;

    logic [CHANNELS-1:0] wr_hit, rd_hit, clr_hit;
    logic [CHANNELS-1:0] is_empty, is_full;
    logic [CHANNELS-1:0] pop_ok, push_ok, push_drop, push_ovw;
    logic [WIDTH-1:0]    dout;

    // Pointers wrap at DEPTH-1 back to 0.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PTR_LAST : p - PW'(1);
    endfunction

    // Decode strobes per channel and classify each push/pop; an out-of-range
    // channel index matches no channel and so has no effect.
    always_comb begin
        wr_hit    = '0;
        rd_hit    = '0;
        clr_hit   = '0;
        is_empty  = '0;
        is_full   = '0;
        pop_ok    = '0;
        push_ok   = '0;
        push_drop = '0;
        push_ovw  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_hit[c]    = bus.mcpu_wr      && (bus.mcpu_ch == CW'(c));
            rd_hit[c]    = bus.scpu_rd      && (bus.scpu_ch == CW'(c));
            clr_hit[c]   = bus.mcpu_clr_ovf && (bus.mcpu_ch == CW'(c));
            is_empty[c]  = (cnt_q[c] == '0);
            is_full[c]   = (cnt_q[c] == CNT_FULL);
            pop_ok[c]    = rd_hit[c] && !is_empty[c];
            // a pop in the same cycle frees the slot, so a full channel still accepts
            push_ok[c]   = wr_hit[c] && (!is_full[c] || pop_ok[c]);
            push_drop[c] = wr_hit[c] && is_full[c] && !pop_ok[c];
            push_ovw[c]  = (OVERWRITE != 0) && push_drop[c];
        end
    end

    // Next-state for pointers, counts, last-read values and overflow flags.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            cnt_d[c]    = cnt_q[c];
            last_d[c]   = last_q[c];
            ovf_d[c]    = ovf_q[c];
            if (push_ok[c]) begin
                wr_ptr_d[c] = ptr_inc(wr_ptr_q[c]);
            end
            if (pop_ok[c]) begin
                rd_ptr_d[c] = ptr_inc(rd_ptr_q[c]);
                last_d[c]   = mem_q[c][rd_ptr_q[c]];
            end
            if (push_ok[c] && !pop_ok[c]) begin
                cnt_d[c] = cnt_q[c] + NW'(1);
            end else if (!push_ok[c] && pop_ok[c]) begin
                cnt_d[c] = cnt_q[c] - NW'(1);
            end
            // clear first so a same-cycle overflow wins
            if (clr_hit[c]) begin
                ovf_d[c] = 1'b0;
            end
            if (push_drop[c]) begin
                ovf_d[c] = 1'b1;
            end
        end
    end

    // Interrupt next-state for the selected mode.
    always_comb begin
        irq_d = 1'b0;
        case (IRQ_MODE)
            1:       irq_d = |(~is_empty);
            2:       irq_d = (|wr_hit) ? 1'b1 : (bus.scpu_irq_ack ? 1'b0 : irq_q);
            default: irq_d = |(push_ok | push_ovw);
        endcase
    end

    // Head of the selected channel, or its last popped value once drained.
    always_comb begin
        dout = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.scpu_ch == CW'(c)) begin
                dout = is_empty[c] ? last_q[c] : mem_q[c][rd_ptr_q[c]];
            end
        end
    end

    // Control state: pointers, counts, last-read, flags and interrupt.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
                last_q[c]   <= '0;
            end
            ovf_q <= '0;
            irq_q <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
                last_q[c]   <= last_d[c];
            end
            ovf_q <= ovf_d;
            irq_q <= irq_d;
        end
    end

    // Entry storage; a push into a full channel in overwrite mode replaces
    // the newest entry, which sits just behind the write pointer.
    always_ff @(posedge clk_sys) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (push_ok[c]) begin
                mem_q[c][wr_ptr_q[c]] <= bus.mcpu_din;
            end else if (push_ovw[c]) begin
                mem_q[c][ptr_dec(wr_ptr_q[c])] <= bus.mcpu_din;
            end
        end
    end

    assign bus.scpu_dout = dout;
    assign bus.scpu_irq  = irq_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_snd_mailbox.sv
// Directed bench for snd_mailbox: four instances cover the default build,
// the legacy latch build (DEPTH=1, OVERWRITE=1, one channel) and interrupt
// modes 2 and 1.
module tb_snd_mailbox;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    snd_mailbox_if #(.WIDTH(8), .CHANNELS(2)) i0 ();
    snd_mailbox_if #(.WIDTH(8), .CHANNELS(1)) i1 ();
    snd_mailbox_if #(.WIDTH(8), .CHANNELS(2)) i2 ();
    snd_mailbox_if #(.WIDTH(8), .CHANNELS(2)) i3 ();

    snd_mailbox #(.WIDTH(8), .DEPTH(4), .CHANNELS(2), .OVERWRITE(0), .IRQ_MODE(0))
        u0 (.clk_sys(clk), .rst_n(rst_n), .bus(i0));
    snd_mailbox #(.WIDTH(8), .DEPTH(1), .CHANNELS(1), .OVERWRITE(1), .IRQ_MODE(0))
        u1 (.clk_sys(clk), .rst_n(rst_n), .bus(i1));
    snd_mailbox #(.WIDTH(8), .DEPTH(4), .CHANNELS(2), .OVERWRITE(0), .IRQ_MODE(2))
        u2 (.clk_sys(clk), .rst_n(rst_n), .bus(i2));
    snd_mailbox #(.WIDTH(8), .DEPTH(4), .CHANNELS(2), .OVERWRITE(0), .IRQ_MODE(1))
        u3 (.clk_sys(clk), .rst_n(rst_n), .bus(i3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic ch, input logic [7:0] d);
        i0.mcpu_wr  = 1'b1;
        i0.mcpu_ch  = ch;
        i0.mcpu_din = d;
        cyc();
        i0.mcpu_wr  = 1'b0;
    endtask

    task automatic pop0(input logic ch, input logic [7:0] exp, input string tag);
        i0.scpu_ch = ch;
        #1;
        check(tag, 32'(i0.scpu_dout), 32'(exp));
        i0.scpu_rd = 1'b1;
        cyc();
        i0.scpu_rd = 1'b0;
    endtask

    task automatic idle_all();
        i0.mcpu_wr = 1'b0; i0.mcpu_ch = '0; i0.mcpu_din = '0; i0.mcpu_clr_ovf = 1'b0;
        i0.scpu_rd = 1'b0; i0.scpu_ch = '0; i0.scpu_irq_ack = 1'b0;
        i1.mcpu_wr = 1'b0; i1.mcpu_ch = '0; i1.mcpu_din = '0; i1.mcpu_clr_ovf = 1'b0;
        i1.scpu_rd = 1'b0; i1.scpu_ch = '0; i1.scpu_irq_ack = 1'b0;
        i2.mcpu_wr = 1'b0; i2.mcpu_ch = '0; i2.mcpu_din = '0; i2.mcpu_clr_ovf = 1'b0;
        i2.scpu_rd = 1'b0; i2.scpu_ch = '0; i2.scpu_irq_ack = 1'b0;
        i3.mcpu_wr = 1'b0; i3.mcpu_ch = '0; i3.mcpu_din = '0; i3.mcpu_clr_ovf = 1'b0;
        i3.scpu_rd = 1'b0; i3.scpu_ch = '0; i3.scpu_irq_ack = 1'b0;
    endtask

    initial begin
        idle_all();
        #12;
        // reset state
        check("rst_empty",    32'(i0.empty),     'h3);
        check("rst_full",     32'(i0.full),      'h0);
        check("rst_ovf",      32'(i0.ovf),       'h0);
        check("rst_irq",      32'(i0.scpu_irq),  'h0);
        check("rst_dout",     32'(i0.scpu_dout), 'h0);
        check("rst_empty_d1", 32'(i1.empty),     'h1);
        check("rst_irq_d3",   32'(i3.scpu_irq),  'h0);
        rst_n = 1'b1;
        cyc();

        // basic FWFT order, IRQ pulse, last-read after drain
        push0(1'b0, 8'h11);
        check("irq0_pulse", 32'(i0.scpu_irq),  'h1);
        check("fwft_head",  32'(i0.scpu_dout), 'h11);
        check("empty0_clr", 32'(i0.empty),     'h2);
        push0(1'b0, 8'h22);
        push0(1'b0, 8'h33);
        cyc();
        check("irq0_idle", 32'(i0.scpu_irq), 'h0);
        pop0(1'b0, 8'h11, "pop_a");
        pop0(1'b0, 8'h22, "pop_b");
        pop0(1'b0, 8'h33, "pop_c");
        check("empty0_set", 32'(i0.empty), 'h3);
        pop0(1'b0, 8'h33, "last_read");
        check("empty_pop_nop", 32'(i0.empty), 'h3);

        // fill ch1, overflow drop, data intact, clear overflow
        for (int i = 0; i < 4; i++) push0(1'b1, 8'(8'hA1 + i));
        check("full1", 32'(i0.full), 'h2);
        push0(1'b1, 8'h99);
        check("ovf1_set",  32'(i0.ovf),      'h2);
        check("irq0_drop", 32'(i0.scpu_irq), 'h0);
        check("full1_keep", 32'(i0.full),    'h2);
        for (int i = 0; i < 4; i++) pop0(1'b1, 8'(8'hA1 + i), "ch1_drain");
        check("empty1", 32'(i0.empty), 'h3);
        check("ovf1_sticky", 32'(i0.ovf), 'h2);
        i0.mcpu_clr_ovf = 1'b1;
        i0.mcpu_ch      = 1'b1;
        cyc();
        i0.mcpu_clr_ovf = 1'b0;
        check("ovf1_clr", 32'(i0.ovf), 'h0);

        // full ch0 with simultaneous push and pop
        for (int i = 0; i < 4; i++) push0(1'b0, 8'(i + 1));
        check("full0", 32'(i0.full), 'h1);
        i0.scpu_ch = 1'b0;
        #1;
        check("simul_head", 32'(i0.scpu_dout), 'h01);
        i0.mcpu_wr = 1'b1; i0.mcpu_ch = 1'b0; i0.mcpu_din = 8'hAA; i0.scpu_rd = 1'b1;
        cyc();
        i0.mcpu_wr = 1'b0; i0.scpu_rd = 1'b0;
        check("simul_full", 32'(i0.full),     'h1);
        check("simul_ovf",  32'(i0.ovf),      'h0);
        check("simul_irq",  32'(i0.scpu_irq), 'h1);
        pop0(1'b0, 8'h02, "simul_p1");
        pop0(1'b0, 8'h03, "simul_p2");
        pop0(1'b0, 8'h04, "simul_p3");
        pop0(1'b0, 8'hAA, "simul_p4");
        check("simul_empty", 32'(i0.empty), 'h3);

        // pointer wrap across three fill/drain rounds
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) push0(1'b0, 8'(8'h40 + 16 * k + i));
            check("wrap_full", 32'(i0.full), 'h1);
            for (int i = 0; i < 4; i++) pop0(1'b0, 8'(8'h40 + 16 * k + i), "wrap_pop");
            check("wrap_empty", 32'(i0.empty), 'h3);
        end

        // legacy latch: DEPTH=1, OVERWRITE=1
        i1.mcpu_wr = 1'b1; i1.mcpu_ch = 1'b0; i1.mcpu_din = 8'h05;
        cyc();
        i1.mcpu_wr = 1'b0;
        check("latch_irq1", 32'(i1.scpu_irq),  'h1);
        check("latch_d05",  32'(i1.scpu_dout), 'h05);
        check("latch_full", 32'(i1.full),      'h1);
        check("latch_ovf0", 32'(i1.ovf),       'h0);
        cyc();
        check("latch_irq_gap", 32'(i1.scpu_irq), 'h0);
        i1.mcpu_wr = 1'b1; i1.mcpu_din = 8'h07;
        cyc();
        i1.mcpu_wr = 1'b0;
        check("latch_irq2", 32'(i1.scpu_irq),  'h1);
        check("latch_d07",  32'(i1.scpu_dout), 'h07);
        check("latch_ovf1", 32'(i1.ovf),       'h1);
        check("latch_full2", 32'(i1.full),     'h1);
        // out-of-range channel on the single-channel build
        i1.mcpu_wr = 1'b1; i1.mcpu_ch = 1'b1; i1.mcpu_din = 8'h33;
        cyc();
        i1.mcpu_wr = 1'b0; i1.mcpu_ch = 1'b0;
        check("badch_irq",  32'(i1.scpu_irq),  'h0);
        check("badch_keep", 32'(i1.scpu_dout), 'h07);
        i1.scpu_ch = 1'b1;
        #1;
        check("badch_dout", 32'(i1.scpu_dout), 'h0);
        i1.scpu_ch = 1'b0;

        // IRQ mode 2: set on push, set beats ack, lone ack clears
        i2.mcpu_wr = 1'b1; i2.mcpu_ch = 1'b0; i2.mcpu_din = 8'h10;
        cyc();
        i2.mcpu_wr = 1'b0;
        check("m2_set", 32'(i2.scpu_irq), 'h1);
        cyc();
        check("m2_hold", 32'(i2.scpu_irq), 'h1);
        i2.mcpu_wr = 1'b1; i2.mcpu_din = 8'h11; i2.scpu_irq_ack = 1'b1;
        cyc();
        i2.mcpu_wr = 1'b0;
        check("m2_set_wins", 32'(i2.scpu_irq), 'h1);
        cyc();
        i2.scpu_irq_ack = 1'b0;
        check("m2_ack_clr", 32'(i2.scpu_irq), 'h0);

        // IRQ mode 1: level of any non-empty, one cycle late
        i3.mcpu_wr = 1'b1; i3.mcpu_ch = 1'b1; i3.mcpu_din = 8'h20;
        cyc();
        i3.mcpu_wr = 1'b0;
        check("m1_lag",   32'(i3.scpu_irq), 'h0);
        check("m1_empty", 32'(i3.empty),    'h1);
        cyc();
        check("m1_high", 32'(i3.scpu_irq), 'h1);
        i3.scpu_ch = 1'b1; i3.scpu_rd = 1'b1;
        cyc();
        i3.scpu_rd = 1'b0;
        check("m1_drained", 32'(i3.empty),    'h3);
        check("m1_still",   32'(i3.scpu_irq), 'h1);
        cyc();
        check("m1_drop", 32'(i3.scpu_irq), 'h0);

        // asynchronous reset with three entries held
        push0(1'b0, 8'hC1);
        push0(1'b0, 8'hC2);
        push0(1'b0, 8'hC3);
        i0.scpu_ch = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_empty", 32'(i0.empty),     'h3);
        check("arst_irq",   32'(i0.scpu_irq),  'h0);
        check("arst_dout",  32'(i0.scpu_dout), 'h0);
        check("arst_full",  32'(i0.full),      'h0);
        #3;
        rst_n = 1'b1;
        push0(1'b0, 8'h5A);
        check("post_rst_dout",  32'(i0.scpu_dout), 'h5A);
        check("post_rst_empty", 32'(i0.empty),     'h2);
        pop0(1'b0, 8'h5A, "post_rst_pop");
        check("post_rst_drain", 32'(i0.empty), 'h3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
